// File: rtl/gate_pattern_checker.sv
// gate_pattern_checker
//   Exhaustive stimulus generator and checker for N-input combinational gate
//   cells. It walks stim through 0 .. 2^N-1 in binary order and holds each
//   pattern for SETTLE_CYC cycles. It then samples dut_f for one cycle and
//   compares it with a reference reduction selected by mode. The run ends
//   with a pass/fail summary.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (honoured only in IDLE or DONE)
//   mode       in   0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal
//   dut_f      in   DUT output, sampled in SAMPLE
//   stim       out  DUT input vector
//   busy       out  high in SETTLE or SAMPLE
//   done       out  high in DONE
//   pass       out  valid with done: no mismatches and legal mode
//   mode_err   out  illegal mode latched for the current run
//   err_count  out  number of mismatching patterns
//   first_err  out  pattern of the first mismatch, 0 if none
module gate_pattern_checker #(
   parameter int unsigned N          = 2,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   mode,
   input  logic         dut_f,
   output logic [N-1:0] stim,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         mode_err,
   output logic [N:0]   err_count,
   output logic [N-1:0] first_err
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam int unsigned     CntW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYC - 1);

   state_e          state_q, state_d;
   logic [2:0]      mode_q, mode_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    stim_q, stim_d;
   logic [N:0]      err_count_q, err_count_d;
   logic [N-1:0]    first_err_q, first_err_d;
   logic            mode_err_q, mode_err_d;
   logic            pass_q, pass_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            exp_f;
   logic            mismatch;

   function automatic logic ref_f(input logic [2:0] m, input logic [N-1:0] v);
      logic r;
      case (m)
         3'd0:    r = ~|v;
         3'd1:    r = ~&v;
         3'd2:    r = &v;
         3'd3:    r = |v;
         3'd4:    r = ^v;
         3'd5:    r = ~^v;
         default: r = 1'b0;  // illegal modes never reach SAMPLE
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      stim_d      = stim_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      mode_err_d  = mode_err_q;
      pass_d      = pass_q;

      exp_f    = ref_f(mode_q, stim_q);
      // Case inequality so an X/Z from the DUT counts as a mismatch.
      mismatch = (dut_f !== exp_f);

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mode_d      = mode;
               err_count_d = '0;
               first_err_d = '0;
               mode_err_d  = 1'b0;
               pass_d      = 1'b0;
               stim_d      = '0;
               cnt_d       = '0;
               if (mode > 3'd5) begin
                  mode_err_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (cnt_q == CntLast) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSample: begin
            if (mismatch) begin
               err_count_d = err_count_q + (N + 1)'(1);
               if (err_count_q == '0) begin
                  first_err_d = stim_q;
               end
            end
            if (&stim_q) begin
               state_d = StDone;
               pass_d  = (err_count_d == '0) && !mode_err_q;
            end else begin
               stim_d  = stim_q + N'(1);
               cnt_d   = '0;
               state_d = StSettle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Status flags are registered copies of the next state.
      busy_d = (state_d == StSettle) || (state_d == StSample);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         mode_q      <= 3'd0;
         cnt_q       <= '0;
         stim_q      <= '0;
         err_count_q <= '0;
         first_err_q <= '0;
         mode_err_q  <= 1'b0;
         pass_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         stim_q      <= stim_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
         mode_err_q  <= mode_err_d;
         pass_q      <= pass_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign stim      = stim_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign mode_err  = mode_err_q;
   assign err_count = err_count_q;
   assign first_err = first_err_q;

endmodule

// File: tb/tb_gate_pattern_checker.sv
module tb_gate_pattern_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run = 0;
   int fails     = 0;

   // Instance A: N=2, SETTLE_CYC=1, DUT model selectable via kind_a.
   logic       start_a = 1'b0;
   logic [2:0] mode_a  = 3'd0;
   logic [1:0] kind_a  = 2'd0;  // 0 correct NOR, 1 stuck-at-0, 2 stuck-at-1
   logic       dut_f_a;
   logic [1:0] stim_a;
   logic       busy_a, done_a, pass_a, mode_err_a;
   logic [2:0] err_a;
   logic [1:0] first_a;

   assign dut_f_a = (kind_a == 2'd0) ? ~|stim_a : (kind_a == 2'd1) ? 1'b0 : 1'b1;

   gate_pattern_checker #(.N(2), .SETTLE_CYC(1)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .mode      (mode_a),
      .dut_f     (dut_f_a),
      .stim      (stim_a),
      .busy      (busy_a),
      .done      (done_a),
      .pass      (pass_a),
      .mode_err  (mode_err_a),
      .err_count (err_a),
      .first_err (first_a)
   );

   // Instance B: N=4, SETTLE_CYC=3, correct NAND DUT.
   logic       start_b = 1'b0;
   logic [2:0] mode_b  = 3'd1;
   logic       dut_f_b;
   logic [3:0] stim_b;
   logic       busy_b, done_b, pass_b, mode_err_b;
   logic [4:0] err_b;
   logic [3:0] first_b;

   assign dut_f_b = ~&stim_b;

   gate_pattern_checker #(.N(4), .SETTLE_CYC(3)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .mode      (mode_b),
      .dut_f     (dut_f_b),
      .stim      (stim_b),
      .busy      (busy_b),
      .done      (done_b),
      .pass      (pass_b),
      .mode_err  (mode_err_b),
      .err_count (err_b),
      .first_err (first_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_a(input logic [2:0] m);
      mode_a  = m;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic go_b(input logic [2:0] m);
      mode_b  = m;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
   endtask

   // Cycles counted after the capturing edge; stops at budget if done never rises.
   task automatic wait_done_a(input int budget, output int cycles);
      cycles = 0;
      while (!done_a && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic wait_done_b(input int budget, output int cycles);
      cycles = 0;
      while (!done_b && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({stim_a, busy_a, done_a, pass_a, mode_err_a, err_a, first_a} !== 11'd0) begin
         fails++;
         $display("FAIL reset_a: outputs %b, expected all zero",
                  {stim_a, busy_a, done_a, pass_a, mode_err_a, err_a, first_a});
      end
      tests_run++;
      if ({stim_b, busy_b, done_b, pass_b, mode_err_b, err_b, first_b} !== 17'd0) begin
         fails++;
         $display("FAIL reset_b: outputs %b, expected all zero",
                  {stim_b, busy_b, done_b, pass_b, mode_err_b, err_b, first_b});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_nor_correct();
      logic [1:0] exp_stim;
      kind_a = 2'd0;
      go_a(3'd0);
      tests_run++;
      if (stim_a !== 2'd0 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL nor_first: stim=%0d busy=%0b, expected stim=0 busy=1", stim_a, busy_a);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_stim = (k < 8) ? 2'(k / 2) : 2'd3;
         tests_run++;
         if (stim_a !== exp_stim || done_a !== (k == 8)) begin
            fails++;
            $display("FAIL nor_seq cycle %0d: stim=%0d done=%0b, expected stim=%0d done=%0b",
                     k, stim_a, done_a, exp_stim, (k == 8));
         end
      end
      tests_run++;
      if (pass_a !== 1'b1 || err_a !== 3'd0 || first_a !== 2'd0 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL nor_result: pass=%0b err=%0d first=%0d busy=%0b, expected 1 0 0 0",
                  pass_a, err_a, first_a, busy_a);
      end
   endtask

   task automatic test_stuck_faults();
      int cyc;
      kind_a = 2'd1;
      go_a(3'd0);
      wait_done_a(20, cyc);
      tests_run++;
      if (cyc !== 8 || err_a !== 3'd1 || first_a !== 2'd0 || pass_a !== 1'b0) begin
         fails++;
         $display("FAIL stuck0: cyc=%0d err=%0d first=%0d pass=%0b, expected 8 1 0 0",
                  cyc, err_a, first_a, pass_a);
      end
      kind_a = 2'd2;
      go_a(3'd0);
      wait_done_a(20, cyc);
      tests_run++;
      if (cyc !== 8 || err_a !== 3'd3 || first_a !== 2'd1 || pass_a !== 1'b0) begin
         fails++;
         $display("FAIL stuck1: cyc=%0d err=%0d first=%0d pass=%0b, expected 8 3 1 0",
                  cyc, err_a, first_a, pass_a);
      end
   endtask

   // XOR reference against a NOR DUT; mode change and start mid-sweep are ignored.
   task automatic test_xor_mode();
      int cyc;
      kind_a = 2'd0;
      go_a(3'd4);
      tick();
      tick();
      mode_a  = 3'd0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tests_run++;
      if (stim_a !== 2'd1 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL xor_restart_ignored: stim=%0d busy=%0b, expected 1 1", stim_a, busy_a);
      end
      wait_done_a(20, cyc);
      tests_run++;
      if (cyc !== 5 || err_a !== 3'd3 || first_a !== 2'd0 || pass_a !== 1'b0) begin
         fails++;
         $display("FAIL xor_result: cyc=%0d err=%0d first=%0d pass=%0b, expected 5 3 0 0",
                  cyc, err_a, first_a, pass_a);
      end
   endtask

   task automatic test_n4_nand();
      int cyc;
      for (int run = 0; run < 2; run++) begin
         go_b(3'd1);
         tests_run++;
         if (busy_b !== 1'b1 || done_b !== 1'b0 || stim_b !== 4'd0) begin
            fails++;
            $display("FAIL n4_start run %0d: busy=%0b done=%0b stim=%0d, expected 1 0 0",
                     run, busy_b, done_b, stim_b);
         end
         wait_done_b(100, cyc);
         tests_run++;
         if (cyc !== 64 || pass_b !== 1'b1 || err_b !== 5'd0 || stim_b !== 4'd15) begin
            fails++;
            $display("FAIL n4_result run %0d: cyc=%0d pass=%0b err=%0d stim=%0d, expected 64 1 0 15",
                     run, cyc, pass_b, err_b, stim_b);
         end
      end
   endtask

   task automatic test_illegal_mode();
      logic busy_seen;
      go_a(3'd7);
      tests_run++;
      if (done_a !== 1'b1 || mode_err_a !== 1'b1 || pass_a !== 1'b0 || stim_a !== 2'd0
          || err_a !== 3'd0) begin
         fails++;
         $display("FAIL illegal: done=%0b mode_err=%0b pass=%0b stim=%0d err=%0d, expected 1 1 0 0 0",
                  done_a, mode_err_a, pass_a, stim_a, err_a);
      end
      busy_seen = busy_a;
      for (int k = 0; k < 4; k++) begin
         tick();
         busy_seen = busy_seen | busy_a | ~done_a;
      end
      tests_run++;
      if (busy_seen !== 1'b0) begin
         fails++;
         $display("FAIL illegal_hold: busy or done-drop seen=%0b, expected 0", busy_seen);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      kind_a = 2'd1;
      go_a(3'd0);
      repeat (4) tick();
      tests_run++;
      if (stim_a !== 2'd2 || err_a !== 3'd1 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL mid_state: stim=%0d err=%0d busy=%0b, expected 2 1 1",
                  stim_a, err_a, busy_a);
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if ({stim_a, busy_a, done_a, pass_a, mode_err_a, err_a, first_a} !== 11'd0) begin
         fails++;
         $display("FAIL async_reset: outputs %b, expected all zero",
                  {stim_a, busy_a, done_a, pass_a, mode_err_a, err_a, first_a});
      end
      tick();
      rst    = 1'b0;
      kind_a = 2'd0;
      tick();
      go_a(3'd0);
      tests_run++;
      if (stim_a !== 2'd0 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_start: stim=%0d busy=%0b, expected 0 1", stim_a, busy_a);
      end
      wait_done_a(20, cyc);
      tests_run++;
      if (cyc !== 8 || err_a !== 3'd0 || pass_a !== 1'b1 || mode_err_a !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_run: cyc=%0d err=%0d pass=%0b mode_err=%0b, expected 8 0 1 0",
                  cyc, err_a, pass_a, mode_err_a);
      end
   endtask

   initial begin
      test_reset();
      test_nor_correct();
      test_stuck_faults();
      test_xor_mode();
      test_n4_nand();
      test_illegal_mode();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
